capture_ctrl: RTL and testbench
===============================

CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Port: clk  input  1  sample clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  asynchronous active-high reset.
REQ-004 Port: start  input  1  single-cycle arm/run request from command logic.
REQ-005 Port: clr_done  input  1  single-cycle clear of capture_done.
REQ-006 Port: smpl_en  input  1  decimated sample strobe; one RAM write per asserted cycle while capturing.
REQ-007 Port: protTrig  input  1  protocol trigger from the SPI/UART trigger unit.
REQ-008 Port: trig_en  input  1  1 = wait for protTrig; 0 = force trigger on the first sample after pre-fill.
REQ-009 Port: trig_pos  input  9  post-trigger sample count, 0..511.
REQ-010 Port: we  output  1  capture RAM write enable.
REQ-011 Port: waddr  output  9  capture RAM write address.
REQ-012 Port: trig_addr  output  9  RAM address of the trigger sample.
REQ-013 Port: armed  output  1  high in ARMED state.
REQ-014 Port: triggered  output  1  high from trigger acceptance until the next start.
REQ-015 Port: capture_done  output  1  sticky completion flag.

Function
REQ-016 The block SHALL implement states IDLE, FILL, ARMED, POST, DONE.
REQ-017 Circular buffer depth SHALL be 512; waddr SHALL wrap 511->0.
REQ-018 start SHALL be honored only in IDLE or DONE: latch trig_pos into tpos_q, clear pre_cnt/post_cnt, clear capture_done and triggered, waddr -> 0, next state FILL; start in FILL/ARMED/POST SHALL be ignored.
REQ-019 we SHALL equal smpl_en AND state in {FILL, ARMED, POST} (combinational, same cycle).
REQ-020 waddr SHALL increment by 1 on the clock edge following every cycle with we=1, and hold otherwise.
REQ-021 FILL: each write increments 10-bit pre_cnt; when a write brings pre_cnt to 512 - tpos_q the next state SHALL be ARMED.
REQ-022 ARMED: trigger condition is smpl_en AND (protTrig OR NOT trig_en); protTrig without smpl_en SHALL be ignored.
REQ-023 On the trigger cycle the sample SHALL be written, trig_addr SHALL capture the current waddr, triggered SHALL set, and next state SHALL be POST, or DONE if tpos_q = 0.
REQ-024 POST: each write increments post_cnt; when a write brings post_cnt to tpos_q the next state SHALL be DONE and capture_done SHALL set on that edge.
REQ-025 DONE: we SHALL be 0; waddr, trig_addr, triggered held; capture_done held until clr_done or start.
REQ-026 clr_done SHALL clear capture_done in any state, state unchanged; clr_done and start in the same DONE cycle SHALL behave as start.
REQ-027 Total samples written per capture SHALL be exactly 512 when trig_en = 0 (pre-fill + trigger + tpos_q - 1 further... i.e. 512 - tpos_q + tpos_q).
REQ-028 trig_pos changes after start SHALL have no effect until the next start.

Reset
REQ-029 rst SHALL immediately force state IDLE, waddr = 0, trig_addr = 0, pre_cnt = post_cnt = 0, tpos_q = 0, armed = 0, triggered = 0, capture_done = 0, we = 0, including mid-capture.
REQ-030 After rst deasserts, no write SHALL occur until a start is accepted.

Verification
REQ-031 trig_pos=256, start, smpl_en continuous, trig_en=1, protTrig pulse 10 cycles after armed rises -> armed after exactly 256 writes, trig_addr = 256 + 10, capture_done after 256 more writes (waddr wraps to 10).
REQ-032 trig_pos=0, trig_en=0, smpl_en every 4th cycle -> 512 writes total, trig_addr = 511, capture_done on the trigger write edge, waddr = 0.
REQ-033 In ARMED, protTrig high on a cycle with smpl_en=0, then low -> no trigger, stays ARMED.
REQ-034 rst asserted in POST mid-capture -> all outputs zero same cycle; start after release -> normal capture from waddr 0.
REQ-035 start pulse during POST -> ignored, capture completes unchanged; start in DONE with clr_done -> capture_done clears, FILL entered.
REQ-036 trig_pos=511, trig_en=0 -> FILL lasts 1 write, trigger on 2nd write (trig_addr=1), 510 post writes, then DONE.

Source files
------------

// File: rtl/capture_ctrl.sv
// Circular-buffer capture sequencer: pre-fills the RAM, arms on a trigger,
// records the post-trigger window, then raises a sticky completion flag.
module capture_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       clr_done,
   input  logic       smpl_en,
   input  logic       protTrig,
   input  logic       trig_en,
   input  logic [8:0] trig_pos,
   output logic       we,
   output logic [8:0] waddr,
   output logic [8:0] trig_addr,
   output logic       armed,
   output logic       triggered,
   output logic       capture_done
);

   // state | meaning
   // IDLE  | after reset, waiting for start; no writes
   // FILL  | pre-trigger fill, counting writes toward the arm threshold
   // ARMED | writing and watching for the trigger sample
   // POST  | writing the post-trigger window
   // DONE  | capture complete, buffer frozen until the next start
   typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE} state_t;

   state_t     state;
   logic [9:0] pre_cnt;
   logic [9:0] post_cnt;
   logic [8:0] tpos_q;
   logic [9:0] fill_target;
   logic       trig_hit;

   // The trigger sample counts toward the post window, so one capture always
   // spans 512 writes; with no post window the trigger is the 512th write.
   assign fill_target = (tpos_q == 9'd0) ? 10'd511 : (10'd512 - {1'b0, tpos_q});
   assign we          = smpl_en & ((state == FILL) | (state == ARMED) | (state == POST));
   assign trig_hit    = smpl_en & (protTrig | ~trig_en);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         waddr        <= 9'd0;
         trig_addr    <= 9'd0;
         pre_cnt      <= 10'd0;
         post_cnt     <= 10'd0;
         tpos_q       <= 9'd0;
         armed        <= 1'b0;
         triggered    <= 1'b0;
         capture_done <= 1'b0;
      end else begin
         if (we)
            waddr <= waddr + 9'd1;
         if (clr_done)
            capture_done <= 1'b0;

         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  tpos_q       <= trig_pos;
                  pre_cnt      <= 10'd0;
                  post_cnt     <= 10'd0;
                  capture_done <= 1'b0;
                  triggered    <= 1'b0;
                  waddr        <= 9'd0;
                  state        <= FILL;
               end
            end
            FILL: begin
               if (smpl_en) begin
                  pre_cnt <= pre_cnt + 10'd1;
                  if (pre_cnt + 10'd1 == fill_target) begin
                     state <= ARMED;
                     armed <= 1'b1;
                  end
               end
            end
            ARMED: begin
               if (trig_hit) begin
                  trig_addr <= waddr;
                  triggered <= 1'b1;
                  armed     <= 1'b0;
                  post_cnt  <= 10'd1;
                  if (tpos_q <= 9'd1) begin
                     state        <= DONE;
                     capture_done <= 1'b1;
                  end else begin
                     state <= POST;
                  end
               end
            end
            POST: begin
               if (smpl_en) begin
                  post_cnt <= post_cnt + 10'd1;
                  if (post_cnt + 10'd1 == {1'b0, tpos_q}) begin
                     state        <= DONE;
                     capture_done <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_capture_ctrl.sv
// Randomized bench for capture_ctrl: a write-count reference model feeds
// scoreboard queues that a negedge monitor drains and compares.
module tb_capture_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, clr_done = 1'b0, smpl_en = 1'b0, protTrig = 1'b0, trig_en = 1'b0;
   logic [8:0] trig_pos = 9'd0;
   logic       we, armed, triggered, capture_done;
   logic [8:0] waddr, trig_addr;

   int checks = 0;
   int errors = 0;

   capture_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .clr_done(clr_done), .smpl_en(smpl_en),
      .protTrig(protTrig), .trig_en(trig_en), .trig_pos(trig_pos), .we(we), .waddr(waddr),
      .trig_addr(trig_addr), .armed(armed), .triggered(triggered), .capture_done(capture_done)
   );

   always #5 clk = ~clk;

   // reference model: a capture is a count of writes; phases follow from the count
   bit         m_cap = 0, m_done = 0, m_trigd = 0;
   int         m_writes = 0, m_trig = -1, m_tpos = 0;
   logic [8:0] exp_addr_q[$];
   logic [8:0] exp_taddr_q[$];
   logic [8:0] exp_final_q[$];
   bit         exp_we = 0, exp_armed = 0, exp_done = 0, exp_trigd = 0;

   function automatic int pre_len(input int tp);
      return (tp == 0) ? 511 : 512 - tp;
   endfunction

   function automatic int post_len(input int tp);
      return (tp == 0) ? 1 : tp;
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // called just after a rising edge: publish expectations for this cycle, apply inputs, advance model
   task automatic drive(input bit s, input bit c, input bit se, input bit pt, input bit te,
                        input logic [8:0] tp);
      exp_armed = m_cap && (m_trig < 0) && (m_writes >= pre_len(m_tpos));
      exp_done  = m_done;
      exp_trigd = m_trigd;
      start = s; clr_done = c; smpl_en = se; protTrig = pt; trig_en = te; trig_pos = tp;
      exp_we = 0;
      if (c) m_done = 0;
      if (!m_cap) begin
         if (s) begin
            m_cap = 1; m_tpos = int'(tp); m_writes = 0; m_trig = -1; m_done = 0; m_trigd = 0;
         end
      end else if (se) begin
         exp_we = 1;
         exp_addr_q.push_back(9'(m_writes % 512));
         if (m_trig < 0 && m_writes >= pre_len(m_tpos) && (pt || !te)) begin
            m_trig  = m_writes;
            m_trigd = 1;
         end
         m_writes++;
         if (m_trig >= 0 && m_writes == m_trig + post_len(m_tpos)) begin
            m_cap  = 0;
            m_done = 1;
            exp_taddr_q.push_back(9'(m_trig % 512));
            exp_final_q.push_back(9'(m_writes % 512));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_we"}, int'(we), 0);
      check({tag, "_waddr"}, int'(waddr), 0);
      check({tag, "_trig_addr"}, int'(trig_addr), 0);
      check({tag, "_armed"}, int'(armed), 0);
      check({tag, "_triggered"}, int'(triggered), 0);
      check({tag, "_capture_done"}, int'(capture_done), 0);
   endtask

   // monitor
   bit prev_done = 0;
   always @(negedge clk) begin
      if (!rst) begin
         check("we", int'(we), int'(exp_we));
         if (we) begin
            if (exp_addr_q.size() == 0) check("waddr_unexpected_write", 1, 0);
            else check("waddr", int'(waddr), int'(exp_addr_q.pop_front()));
         end
         check("armed", int'(armed), int'(exp_armed));
         check("triggered", int'(triggered), int'(exp_trigd));
         check("capture_done", int'(capture_done), int'(exp_done));
         if (capture_done && !prev_done) begin
            if (exp_taddr_q.size() == 0) check("done_unexpected", 1, 0);
            else begin
               check("trig_addr", int'(trig_addr), int'(exp_taddr_q.pop_front()));
               check("final_waddr", int'(waddr), int'(exp_final_q.pop_front()));
            end
         end
         prev_done = capture_done;
      end else begin
         prev_done = 0;
      end
   end

   initial begin
      int tpos_list[10] = '{256, 0, 511, 1, 300, 2, 100, 450, 17, 384};
      int cyc = 0;
      #2;
      check_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) drive(0, 0, 1, 1, 0, 9'd5);

      for (int n = 0; n < 10; n++) begin
         bit te;
         int budget;
         logic [8:0] tp;
         bit did_rst;
         tp = 9'(tpos_list[n]);
         te = (n == 0) ? 1'b1 : (n == 1 || n == 2) ? 1'b0 : 1'($urandom_range(0, 1));
         did_rst = 0;
         drive(1, (n == 3), 0, 0, te, tp);
         budget = 0;
         while (m_cap && budget < 8000) begin
            bit se, pt;
            cyc++;
            budget++;
            if (n == 0) se = 1;
            else if (n == 1) se = ((cyc % 4) == 0);
            else se = 1'($urandom_range(0, 1));
            pt = ($urandom_range(0, 15) == 0);
            if (n == 4 && !did_rst && m_trig >= 0 && m_writes > m_trig + 3) begin
               // asynchronous reset in the middle of the post window
               rst = 1'b1; smpl_en = 1'b1;
               #1;
               check_all_zero("midrst");
               m_cap = 0; m_done = 0; m_trigd = 0;
               exp_addr_q.delete(); exp_taddr_q.delete(); exp_final_q.delete();
               exp_we = 0; exp_armed = 0; exp_done = 0; exp_trigd = 0;
               @(posedge clk); #1;
               rst = 1'b0;
               drive(0, 0, 1, 1, 0, 9'd0);
               drive(1, 0, 1, 0, te, tp);
               did_rst = 1;
               continue;
            end
            drive(($urandom_range(0, 63) == 0), 0, se, pt, te, 9'($urandom));
         end
         if (m_cap) begin
            check("capture_timeout", 1, 0);
            break;
         end
         for (int k = 0; k < 6; k++)
            drive(0, (k == 3 && n % 2 == 1), 1'($urandom_range(0, 1)), 1, 0, 9'($urandom));
      end

      drive(0, 0, 0, 0, 0, 9'd0);
      drive(0, 0, 0, 0, 0, 9'd0);
      check("leftover_writes", exp_addr_q.size(), 0);
      check("leftover_done", exp_taddr_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
